// File: rtl/fieldious_pkg.sv
// fieldious_pkg: shared constants and types for the query streaming path.
// Holds the query_streamer FSM state type and the default patch geometry.
package fieldious_pkg;

  localparam int unsigned QS_DATA_WIDTH = 11;
  localparam int unsigned QS_PATCH_SIZE = 5;
  localparam int unsigned QS_NUM_QUERYS = 494;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } qs_state_e;

endpackage

// File: rtl/qs_fifo2.sv
// qs_fifo2: two-entry FIFO with flush, used to decouple SRAM reads from the sink.
// Simultaneous push and pop keep occupancy unchanged.
module qs_fifo2 #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             valid_o,
  output logic [1:0]       count_o
);

  logic [Width-1:0] mem_q [2];
  logic [Width-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  // Pointer, occupancy and storage update; flush empties without touching data.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/query_streamer.sv
// query_streamer: streams every query patch from the query SRAM to a valid/ready sink.
// Reads are credit-limited so the two-entry FIFO can never overflow.
// Optional: define QS_STALL_CNT_EN to add stall_cnt_o, a saturating count of cycles
// where a patch is offered but refused.
module query_streamer
  import fieldious_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = QS_DATA_WIDTH,
  parameter int unsigned PATCH_SIZE = QS_PATCH_SIZE,
  parameter int unsigned NUM_QUERYS = QS_NUM_QUERYS,
  parameter int unsigned ADDRW      = $clog2(NUM_QUERYS)
) (
  input  logic                             wb_clk_i,
  input  logic                             wb_rst_i,
  input  logic                             start_i,
  input  logic                             abort_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             mem_csb0_o,
  output logic                             mem_web0_o,
  output logic [ADDRW-1:0]                 mem_addr0_o,
  input  logic [PATCH_SIZE*DATA_WIDTH-1:0] mem_rpatch0_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [PATCH_SIZE*DATA_WIDTH-1:0] out_patch_o,
  output logic [ADDRW-1:0]                 out_idx_o,
  output logic                             out_last_o
`ifdef QS_STALL_CNT_EN
  ,
  output logic [31:0]                      stall_cnt_o
`endif
);

  localparam int unsigned PatchW = PATCH_SIZE * DATA_WIDTH;
  localparam int unsigned EntryW = ADDRW + PatchW;
  localparam logic [ADDRW-1:0] LastAddr = ADDRW'(NUM_QUERYS - 1);

  qs_state_e        state_q, state_d;
  logic [ADDRW-1:0] rd_addr_q, rd_addr_d;
  logic             pend_q, pend_d;
  logic [ADDRW-1:0] pend_addr_q, pend_addr_d;

  logic              flush;
  logic              pop;
  logic              issue;
  logic              start_go;
  logic [1:0]        fifo_count;
  logic [1:0]        occ_after_pop;
  logic              fifo_valid;
  logic [EntryW-1:0] fifo_head;
  logic [ADDRW-1:0]  head_idx;

  assign head_idx      = fifo_head[EntryW-1:PatchW];
  assign pop           = fifo_valid && out_ready_i;
  assign occ_after_pop = fifo_count - {1'b0, pop};
  assign start_go      = (state_q == StIdle) && start_i && !abort_i;

  // A read is allowed when the entry being popped this cycle frees room for it, so a
  // sink that is always ready gets one patch per cycle.
  assign issue = (state_q == StRun) && !abort_i &&
                 ((occ_after_pop + {1'b0, pend_q}) < 2'd2);

  // Next-state logic for the FSM, read address counter and in-flight read tracker.
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    pend_d      = issue;
    pend_addr_d = issue ? rd_addr_q : pend_addr_q;
    flush       = 1'b0;
    if (abort_i) begin
      state_d   = StIdle;
      rd_addr_d = '0;
      pend_d    = 1'b0;
      flush     = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_d   = StRun;
            rd_addr_d = '0;
          end
        end
        StRun: begin
          if (issue) begin
            if (rd_addr_q == LastAddr) begin
              state_d   = StDrain;
              rd_addr_d = '0;
            end else begin
              rd_addr_d = rd_addr_q + ADDRW'(1);
            end
          end
        end
        StDrain: begin
          // Done once the final entry leaves the FIFO this cycle and nothing is in flight.
          if (!pend_q && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
            state_d = StDone;
          end
        end
        StDone: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM and read-tracking registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= StIdle;
      rd_addr_q   <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  qs_fifo2 #(
    .Width(EntryW)
  ) u_fifo (
    .clk_i  (wb_clk_i),
    .rst_i  (wb_rst_i),
    .flush_i(flush),
    .push_i (pend_q),
    .data_i ({pend_addr_q, mem_rpatch0_i}),
    .pop_i  (pop),
    .data_o (fifo_head),
    .valid_o(fifo_valid),
    .count_o(fifo_count)
  );

  assign mem_csb0_o  = ~issue;
  assign mem_web0_o  = 1'b1;
  assign mem_addr0_o = rd_addr_q;

  assign busy_o = (state_q != StIdle);
  assign done_o = (state_q == StDone);

  // Payload is forced to zero while nothing is offered.
  assign out_valid_o = fifo_valid;
  assign out_patch_o = fifo_valid ? fifo_head[PatchW-1:0] : '0;
  assign out_idx_o   = fifo_valid ? head_idx : '0;
  assign out_last_o  = fifo_valid && (head_idx == LastAddr);

`ifdef QS_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of offered-but-refused cycles, restarted by each accepted start.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (start_go) begin
      stall_cnt_d = '0;
    end else if (fifo_valid && !out_ready_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  logic unused_start_go;
  assign unused_start_go = start_go;
`endif

endmodule

// File: doc/query_streamer.md
QUERY_STREAMER -- requirements
Module: query_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 11, bits per patch element.
REQ-002 SHALL have parameter PATCH_SIZE, default 5, elements per query patch.
REQ-003 SHALL have parameter NUM_QUERYS, default 494, number of query patches held in query memory.
REQ-004 SHALL have parameter ADDRW, default $clog2(NUM_QUERYS), query memory address width.
REQ-005 SHALL have port wb_clk_i, input, 1, clock; all logic on rising edge.
REQ-006 SHALL have port wb_rst_i, input, 1, reset, asynchronous, active-high.
REQ-007 SHALL have port start_i, input, 1, single-cycle request to stream all queries.
REQ-008 SHALL have port abort_i, input, 1, synchronous cancel of the current stream.
REQ-009 SHALL have port busy_o, output, 1, high from the first RUN cycle through the DONE cycle.
REQ-010 SHALL have port done_o, output, 1, one-cycle pulse after the last patch is accepted.
REQ-011 SHALL have port mem_csb0_o, output, 1, query memory chip select, active-low.
REQ-012 SHALL have port mem_web0_o, output, 1, query memory write enable, active-low, held at 1.
REQ-013 SHALL have port mem_addr0_o, output, ADDRW, query memory read address.
REQ-014 SHALL have port mem_rpatch0_i, input, PATCH_SIZE*DATA_WIDTH, read data, valid one cycle after csb0 low.
REQ-015 SHALL have port out_valid_o, output, 1, patch available downstream.
REQ-016 SHALL have port out_ready_i, input, 1, downstream accepts; transfer when valid&ready.
REQ-017 SHALL have port out_patch_o, output, PATCH_SIZE*DATA_WIDTH, query patch.
REQ-018 SHALL have port out_idx_o, output, ADDRW, query index of out_patch_o.
REQ-019 SHALL have port out_last_o, output, 1, high with index NUM_QUERYS-1.

Function
REQ-020 SHALL implement FSM IDLE -> RUN on start_i; RUN -> DRAIN after issuing read NUM_QUERYS-1; DRAIN -> DONE when FIFO empty and no read in flight; DONE -> IDLE unconditionally.
REQ-021 SHALL ignore start_i outside IDLE.
REQ-022 SHALL, in any state, go to IDLE on abort_i, flushing FIFO and in-flight read, no done_o; abort_i wins over simultaneous start_i.
REQ-023 SHALL issue reads in RUN only when FIFO occupancy plus in-flight reads < 2, with addresses ascending from 0, no skips or repeats.
REQ-024 SHALL capture mem_rpatch0_i with its address into a 2-entry FIFO at the edge after the read cycle.
REQ-025 SHALL drive out_* from FIFO head; out_valid_o = FIFO not empty; out_* stable while valid&!ready.
REQ-026 SHALL give latency: start_i in cycle 0 -> csb0 low addr 0 in cycle 1 -> out_valid_o in cycle 3.
REQ-027 SHALL sustain one transfer per cycle with out_ready_i held high.
REQ-028 SHALL handle simultaneous FIFO push and pop with unchanged occupancy.
REQ-029 SHALL assert done_o and busy_o in DONE cycle only; busy_o low in IDLE.

Reset
REQ-030 SHALL on wb_rst_i set state IDLE, FIFO empty, counters 0, mem_csb0_o=1, mem_web0_o=1, all other outputs 0.
REQ-031 SHALL, on reset mid-stream, discard all data; out_valid_o low the cycle after assertion.

Configuration
REQ-032 SHALL, with QS_STALL_CNT_EN defined, add output stall_cnt_o (32 bits) counting cycles with out_valid_o&!out_ready_i, cleared on start_i, saturating at all-ones.
REQ-033 SHALL, without QS_STALL_CNT_EN, omit stall_cnt_o and its counter.

Structure
REQ-034 SHALL place the FSM state enum and default DATA_WIDTH/PATCH_SIZE/NUM_QUERYS constants in shared package fieldious_pkg.
REQ-035 SHALL implement the 2-entry FIFO as sub-module qs_fifo2.

Verification
REQ-036 Memory preloaded patch[i]=i, ready high, start -> 494 transfers idx 0..493 back-to-back, last only at 493, done_o at cycle 3+494.
REQ-037 Ready toggled 1010 pattern -> all 494 patches delivered in order, none dropped or duplicated, out_* stable while stalled.
REQ-038 Ready low 20 cycles after first valid -> at most 2 reads issued, patch 0 held, resumes with idx 1.
REQ-039 abort_i at idx 100 with start_i at same cycle -> IDLE next cycle, no done_o, new start restarts at idx 0.
REQ-040 wb_rst_i mid-stream -> csb0=1, out_valid_o=0, busy_o=0; start re-issues from addr 0.
REQ-041 QS_STALL_CNT_EN defined, 37 stall cycles -> stall_cnt_o=37; next start clears to 0.
